// File: rtl/tnn_feature_loader.sv
// Input stage for the ternary-network classifier: assembles a streamed feature
// vector, holds it through a settling window, then hands the prediction downstream.
module tnn_feature_loader #(
  parameter int FEAT_CNT      = 11,
  parameter int FEAT_BITS     = 4,
  parameter int CLASS_CNT     = 7,
  parameter int SETTLE_CYCLES = 2,
  localparam int CLS_W        = $clog2(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [FEAT_BITS-1:0]          s_data,
  input  logic                          s_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] features,
  input  logic [CLS_W-1:0]              prediction,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [CLS_W-1:0]              m_class,
  output logic                          frame_err
);

  localparam int IDX_W = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int VEC_W = FEAT_CNT * FEAT_BITS;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FEAT_CNT - 1);
  localparam logic [SET_W-1:0] SETTLE_INIT = SET_W'(SETTLE_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_ONE  = SET_W'(1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SETTLE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [VEC_W-1:0]   shadow_q, shadow_d;
  logic [VEC_W-1:0]   features_q, features_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [CLS_W-1:0]   m_class_q, m_class_d;
  logic               m_valid_q, m_valid_d;
  logic               frame_err_q, frame_err_d;

  logic beat_acc;
  logic at_last;
  logic frame_ok;
  logic frame_bad;

  assign s_ready   = (state_q == LOAD);
  assign beat_acc  = s_valid & s_ready;
  assign at_last   = (idx_q == LAST_IDX);
  assign frame_ok  = beat_acc & s_last & at_last;
  assign frame_bad = beat_acc & (s_last ^ at_last);

  // The current beat is merged here so the final beat reaches features on its own edge.
  always_comb begin
    shadow_d = shadow_q;
    for (int i = 0; i < FEAT_CNT; i++) begin
      if (beat_acc && (idx_q == IDX_W'(i))) begin
        shadow_d[i*FEAT_BITS +: FEAT_BITS] = s_data;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    features_d  = features_q;
    settle_d    = settle_q;
    m_class_d   = m_class_q;
    m_valid_d   = m_valid_q;
    frame_err_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (frame_ok) begin
          features_d = shadow_d;
          idx_d      = '0;
          settle_d   = SETTLE_INIT;
          state_d    = SETTLE;
        end else if (frame_bad) begin
          frame_err_d = 1'b1;
          idx_d       = '0;
        end else if (beat_acc) begin
          idx_d = idx_q + 1'b1;
        end
      end

      SETTLE: begin
        settle_d = settle_q - 1'b1;
        if (settle_q == SETTLE_ONE) begin
          m_class_d = prediction;
          m_valid_d = 1'b1;
          state_d   = OUTPUT;
        end
      end

      OUTPUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          state_d   = LOAD;
        end
      end

      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      idx_q       <= '0;
      shadow_q    <= '0;
      features_q  <= '0;
      settle_q    <= '0;
      m_class_q   <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      features_q  <= features_d;
      settle_q    <= settle_d;
      m_class_q   <= m_class_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign features  = features_q;
  assign m_class   = m_class_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;

endmodule
